// File: rtl/reset_generator.sv
// reset_generator: turns the PLL lock indication into the clk_1x system reset.
// pll_locked is synchronised, must stay high for LOCK_STABLE_CYCLES, then
// system_reset is held for HOLD_CYCLES more before release. Lock loss in RUN
// or a CPU soft-reset request re-asserts system_reset.
module reset_generator #(
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned LOCK_STABLE_CYCLES = 64,
  parameter int unsigned HOLD_CYCLES        = 16
) (
  input  logic clk_1x,
  input  logic reset,
  input  logic pll_locked,
  input  logic soft_reset_req,
  input  logic lock_lost_clear,
  output logic system_reset,
  output logic reset_done,
  output logic lock_lost
);

  localparam int unsigned MAX_CYCLES =
    (LOCK_STABLE_CYCLES > HOLD_CYCLES) ? LOCK_STABLE_CYCLES : HOLD_CYCLES;
  localparam int unsigned CNT_W = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [CNT_W-1:0]       count;
  logic [CNT_W-1:0]       count_next;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  logic                   lock_lost_set;

  // Multi-flop synchroniser for the asynchronous PLL lock input.
  always_ff @(posedge clk_1x) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign locked_s = sync_q[SYNC_STAGES-1];

  // Next-state and counter logic; the counter is cleared on every state entry
  // and only advances while below its terminal value, so it never wraps.
  always_comb begin
    state_next    = state;
    count_next    = count;
    lock_lost_set = 1'b0;
    case (state)
      WAIT_LOCK: begin
        if (locked_s) begin
          state_next = STABILIZE;
          count_next = '0;
        end
      end
      STABILIZE: begin
        if (!locked_s) begin
          state_next = WAIT_LOCK;
          count_next = '0;
        end else if (count == STABLE_LAST) begin
          state_next = HOLD;
          count_next = '0;
        end else begin
          count_next = count + CNT_W'(1);
        end
      end
      HOLD: begin
        if (!locked_s) begin
          state_next = WAIT_LOCK;
          count_next = '0;
        end else if (count == HOLD_LAST) begin
          state_next = RUN;
          count_next = '0;
        end else begin
          count_next = count + CNT_W'(1);
        end
      end
      RUN: begin
        // Lock loss takes priority over a simultaneous soft-reset request.
        if (!locked_s) begin
          state_next    = WAIT_LOCK;
          count_next    = '0;
          lock_lost_set = 1'b1;
        end else if (soft_reset_req) begin
          state_next = HOLD;
          count_next = '0;
        end
      end
      default: begin
        state_next = WAIT_LOCK;
        count_next = '0;
      end
    endcase
  end

  // State register plus registered outputs; system_reset is decoded from
  // state_next so it toggles on the same edge as the state, straight from a flop.
  always_ff @(posedge clk_1x) begin
    if (reset) begin
      state        <= WAIT_LOCK;
      count        <= '0;
      system_reset <= 1'b1;
      reset_done   <= 1'b0;
      lock_lost    <= 1'b0;
    end else begin
      state        <= state_next;
      count        <= count_next;
      system_reset <= (state_next != RUN);
      reset_done   <= (state_next == RUN) && (state != RUN);
      lock_lost    <= lock_lost_set | (lock_lost & ~lock_lost_clear);
    end
  end

endmodule

// File: tb/tb_reset_generator.sv
// Directed self-checking bench for reset_generator (2 / 4 / 8 configuration).
module tb_reset_generator;

  logic clk_1x = 1'b0;
  logic reset = 1'b1;
  logic pll_locked = 1'b0;
  logic soft_reset_req = 1'b0;
  logic lock_lost_clear = 1'b0;
  logic system_reset;
  logic reset_done;
  logic lock_lost;

  int checks = 0;
  int errors = 0;

  reset_generator #(
    .SYNC_STAGES(2),
    .LOCK_STABLE_CYCLES(4),
    .HOLD_CYCLES(8)
  ) dut (
    .clk_1x(clk_1x),
    .reset(reset),
    .pll_locked(pll_locked),
    .soft_reset_req(soft_reset_req),
    .lock_lost_clear(lock_lost_clear),
    .system_reset(system_reset),
    .reset_done(reset_done),
    .lock_lost(lock_lost)
  );

  always #5 clk_1x = ~clk_1x;

  // One active edge, then settle before inputs change or outputs are sampled.
  task automatic tick();
    @(posedge clk_1x);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    pll_locked = 1'b0;
    soft_reset_req = 1'b0;
    lock_lost_clear = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  // From post-reset WAIT_LOCK: lock, wait out 15 edges, plus one so reset_done is low.
  task automatic bring_up();
    pll_locked = 1'b1;
    repeat (16) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pll_locked = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (system_reset !== 1'b1) begin errors++; $display("FAIL reset_sr cyc %0d: got %b want 1", i, system_reset); end
      checks++; if (reset_done !== 1'b0) begin errors++; $display("FAIL reset_done cyc %0d: got %b want 0", i, reset_done); end
      checks++; if (lock_lost !== 1'b0) begin errors++; $display("FAIL reset_ll cyc %0d: got %b want 0", i, lock_lost); end
    end
    reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      checks++; if (system_reset !== 1'b1 || reset_done !== 1'b0) begin errors++; $display("FAIL wait_lock_idle cyc %0d: got sr=%b rd=%b want sr=1 rd=0", i, system_reset, reset_done); end
    end
  endtask

  task automatic test_clean_lock();
    apply_reset();
    pll_locked = 1'b1;
    for (int i = 0; i <= 14; i++) begin
      tick();
      checks++; if (system_reset !== (i < 14 ? 1'b1 : 1'b0)) begin errors++; $display("FAIL clean_sr edge %0d: got %b want %b", i, system_reset, (i < 14)); end
      checks++; if (reset_done !== (i == 14 ? 1'b1 : 1'b0)) begin errors++; $display("FAIL clean_done edge %0d: got %b want %b", i, reset_done, (i == 14)); end
    end
    tick();
    checks++; if (reset_done !== 1'b0 || system_reset !== 1'b0) begin errors++; $display("FAIL clean_after edge 15: got sr=%b rd=%b want sr=0 rd=0", system_reset, reset_done); end
  endtask

  task automatic test_lock_glitch();
    apply_reset();
    pll_locked = 1'b1;
    repeat (3) tick();
    pll_locked = 1'b0;
    repeat (2) tick();
    pll_locked = 1'b1;
    for (int i = 0; i <= 14; i++) begin
      tick();
      checks++; if (system_reset !== (i < 14 ? 1'b1 : 1'b0)) begin errors++; $display("FAIL glitch_sr edge %0d: got %b want %b", i, system_reset, (i < 14)); end
      checks++; if (lock_lost !== 1'b0) begin errors++; $display("FAIL glitch_ll edge %0d: got %b want 0", i, lock_lost); end
    end
  endtask

  task automatic test_lock_loss();
    apply_reset();
    bring_up();
    pll_locked = 1'b0;
    for (int i = 0; i <= 2; i++) begin
      tick();
      checks++; if (system_reset !== (i == 2 ? 1'b1 : 1'b0)) begin errors++; $display("FAIL loss_sr edge %0d: got %b want %b", i, system_reset, (i == 2)); end
      checks++; if (lock_lost !== (i == 2 ? 1'b1 : 1'b0)) begin errors++; $display("FAIL loss_ll edge %0d: got %b want %b", i, lock_lost, (i == 2)); end
    end
    repeat (2) tick();
    pll_locked = 1'b1;
    for (int i = 0; i <= 14; i++) begin
      tick();
      checks++; if (system_reset !== (i < 14 ? 1'b1 : 1'b0)) begin errors++; $display("FAIL relock_sr edge %0d: got %b want %b", i, system_reset, (i < 14)); end
      checks++; if (lock_lost !== 1'b1) begin errors++; $display("FAIL relock_ll edge %0d: got %b want 1", i, lock_lost); end
    end
    lock_lost_clear = 1'b1;
    tick();
    lock_lost_clear = 1'b0;
    checks++; if (lock_lost !== 1'b0) begin errors++; $display("FAIL ll_clear: got %b want 0", lock_lost); end
  endtask

  task automatic test_soft_reset();
    apply_reset();
    bring_up();
    soft_reset_req = 1'b1;
    tick();
    soft_reset_req = 1'b0;
    checks++; if (system_reset !== 1'b1) begin errors++; $display("FAIL soft_assert: got %b want 1", system_reset); end
    for (int i = 1; i <= 8; i++) begin
      // Second request lands in HOLD and must not extend the hold.
      soft_reset_req = (i == 3);
      tick();
      checks++; if (system_reset !== (i < 8 ? 1'b1 : 1'b0)) begin errors++; $display("FAIL soft_sr edge +%0d: got %b want %b", i, system_reset, (i < 8)); end
      checks++; if (reset_done !== (i == 8 ? 1'b1 : 1'b0)) begin errors++; $display("FAIL soft_done edge +%0d: got %b want %b", i, reset_done, (i == 8)); end
    end
    soft_reset_req = 1'b0;
    tick();
    checks++; if (reset_done !== 1'b0 || system_reset !== 1'b0 || lock_lost !== 1'b0) begin errors++; $display("FAIL soft_after: got sr=%b rd=%b ll=%b want 0 0 0", system_reset, reset_done, lock_lost); end
  endtask

  task automatic test_corners();
    // Lock loss and soft reset seen by RUN in the same cycle.
    apply_reset();
    bring_up();
    pll_locked = 1'b0;
    repeat (2) tick();
    soft_reset_req = 1'b1;
    tick();
    soft_reset_req = 1'b0;
    checks++; if (system_reset !== 1'b1 || lock_lost !== 1'b1) begin errors++; $display("FAIL corner_loss_vs_soft: got sr=%b ll=%b want sr=1 ll=1", system_reset, lock_lost); end

    // Clear coincides with a new set.
    apply_reset();
    bring_up();
    pll_locked = 1'b0;
    repeat (2) tick();
    lock_lost_clear = 1'b1;
    tick();
    lock_lost_clear = 1'b0;
    checks++; if (lock_lost !== 1'b1) begin errors++; $display("FAIL corner_set_vs_clear: got %b want 1", lock_lost); end

    // Reset in the middle of HOLD restarts the whole sequence.
    apply_reset();
    pll_locked = 1'b1;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (system_reset !== 1'b1 || reset_done !== 1'b0) begin errors++; $display("FAIL corner_reset_hold: got sr=%b rd=%b want sr=1 rd=0", system_reset, reset_done); end
    for (int i = 0; i <= 14; i++) begin
      tick();
      checks++; if (system_reset !== (i < 14 ? 1'b1 : 1'b0)) begin errors++; $display("FAIL corner_rehold_sr edge %0d: got %b want %b", i, system_reset, (i < 14)); end
    end
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_lock_glitch();
    test_lock_loss();
    test_soft_reset();
    test_corners();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
